// File: rtl/wb_cache_ctrl_if.sv
// Request/response and backing-memory signals of wb_cache_ctrl.
// slave = the cache controller; master = the CPU and memory around it.
interface wb_cache_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/wb_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller, word-serial memory port.
// Optional hit/miss counters when CACHE_STATS_EN is defined. TAG_W must be >= 1.
module wb_cache_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned INDEX_W  = 7,
  parameter int unsigned OFFSET_W = 2
) (
  input  logic           clk,
  input  logic           rst,
  wb_cache_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]    hit_count,
  output logic [31:0]    miss_count
`endif
);

  localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned WORDS  = 1 << (INDEX_W + OFFSET_W);
  localparam int unsigned WADR_W = INDEX_W + OFFSET_W;
  localparam logic [OFFSET_W-1:0] LAST_WORD = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_FILL, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic                resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]    tag_mem  [LINES];
  logic [DATA_W-1:0]   data_mem [WORDS];

  logic                tag_we;
  logic                data_we;
  logic [WADR_W-1:0]   data_waddr;
  logic [DATA_W-1:0]   data_wdata;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic [TAG_W-1:0]    line_tag;
  logic                hit;
  logic                victim_dirty;
  logic                mem_fire;
  logic                last_word;
  logic [DATA_W-1:0]   word_rd;

  assign req_tag      = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx      = addr_q[OFFSET_W +: INDEX_W];
  assign req_off      = addr_q[OFFSET_W-1:0];
  assign line_tag     = tag_mem[req_idx];
  assign hit          = valid_q[req_idx] && (line_tag == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];
  assign mem_fire     = mem_req_q && bus.mem_ack;
  assign last_word    = (cnt_q == LAST_WORD);
  assign word_rd      = data_mem[{req_idx, req_off}];

  // State and control registers; line valid/dirty bits clear in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Tag and data arrays carry no reset; valid_q gates their use.
  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_mem[req_idx] <= req_tag;
    end
    if (data_we) begin
      data_mem[data_waddr] <= data_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          state_d = S_IDLE;
        end else if (victim_dirty) begin
          state_d = S_WB;
        end else begin
          state_d = S_FILL;
        end
      end
      S_WB: begin
        if (mem_fire && last_word) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_fire && last_word) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath, memory-port and response next values.
  always_comb begin
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    tag_we       = 1'b0;
    data_we      = 1'b0;
    data_waddr   = {req_idx, req_off};
    data_wdata   = wdata_q;
    req_ready_d  = (state_d == S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          if (we_q) begin
            data_we           = 1'b1;
            dirty_d[req_idx]  = 1'b1;
            resp_rdata_d      = wdata_q;
          end else begin
            resp_rdata_d      = word_rd;
          end
        end else begin
          // Line is invalid until the refill completes, so an abort leaves it unusable.
          valid_d[req_idx] = 1'b0;
          cnt_d            = '0;
        end
      end
      S_WB: begin
        if (!mem_req_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {line_tag, req_idx, cnt_q};
          mem_wdata_d = data_mem[{req_idx, cnt_q}];
        end else if (bus.mem_ack) begin
          cnt_d = cnt_q + OFFSET_W'(1);
          if (last_word) begin
            mem_req_d        = 1'b0;
            dirty_d[req_idx] = 1'b0;
          end else begin
            mem_addr_d  = {line_tag, req_idx, cnt_d};
            mem_wdata_d = data_mem[{req_idx, cnt_d}];
          end
        end
      end
      S_FILL: begin
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {req_tag, req_idx, cnt_q};
        end else if (bus.mem_ack) begin
          data_we    = 1'b1;
          data_waddr = {req_idx, cnt_q};
          data_wdata = bus.mem_rdata;
          cnt_d      = cnt_q + OFFSET_W'(1);
          if (last_word) begin
            mem_req_d        = 1'b0;
            tag_we           = 1'b1;
            valid_d[req_idx] = 1'b1;
          end else begin
            mem_addr_d = {req_tag, req_idx, cnt_d};
          end
        end
      end
      S_DONE: begin
        resp_valid_d = 1'b1;
        if (we_q) begin
          data_we          = 1'b1;
          dirty_d[req_idx] = 1'b1;
          resp_rdata_d     = wdata_q;
        end else begin
          resp_rdata_d     = word_rd;
        end
      end
      default: ;
    endcase
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Saturating counters, one step per response pulse.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (resp_valid_q) begin
      if (resp_hit_q) begin
        if (hit_count_q != 32'hFFFF_FFFF) hit_count_d = hit_count_q + 32'd1;
      end else begin
        if (miss_count_q != 32'hFFFF_FFFF) miss_count_d = miss_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Directed bench for wb_cache_ctrl: memory model returns addr^0xA5A5 and logs every word.
// Counter checks are compiled in only when CACHE_STATS_EN is defined.
module tb_wb_cache_ctrl;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_accept = 0;
  int   n_resp   = 0;
  int   mem_lat  = 3;

  logic        log_we   [$];
  logic [15:0] log_addr [$];
  logic [15:0] log_data [$];

  wb_cache_ctrl_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  wb_cache_ctrl #(.ADDR_W(16), .DATA_W(16), .INDEX_W(7), .OFFSET_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.req_valid && bus.req_ready) n_accept <= n_accept + 1;
    if (bus.resp_valid) n_resp <= n_resp + 1;
  end

  // Memory model: acks after mem_lat idle negedges, logs each completed word.
  initial begin
    int wait_cnt;
    wait_cnt      = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
        wait_cnt    = 0;
      end else if (!bus.mem_req) begin
        wait_cnt = 0;
      end else if (wait_cnt >= mem_lat) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_addr ^ 16'hA5A5;
        log_we.push_back(bus.mem_we);
        log_addr.push_back(bus.mem_addr);
        log_data.push_back(bus.mem_we ? bus.mem_wdata : (bus.mem_addr ^ 16'hA5A5));
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int count_writes(input int from);
    int n = 0;
    for (int i = from; i < log_we.size(); i++) if (log_we[i]) n++;
    return n;
  endfunction

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        output logic hit, output logic [15:0] rd, output int lat);
    int guard = 0;
    @(negedge clk); #1;
    while (!bus.req_ready && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 500) begin
      @(negedge clk); #1;
      lat++;
    end
    if (!bus.resp_valid) check("resp_timeout", 32'd0, 32'd1);
    hit = bus.resp_hit;
    rd  = bus.resp_rdata;
  endtask

  initial begin
    logic        hit;
    logic [15:0] rd;
    int          lat;
    int          base;
    int          guard;
    int          seen;
    int          acc_base;
    int          resp_base;
    logic        hits [2];

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("rst_req_ready",  32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
    check("rst_mem_req",    32'(bus.mem_req),    32'd0);
    check("rst_mem_addr",   32'(bus.mem_addr),   32'd0);
    check("rst_mem_we",     32'(bus.mem_we),     32'd0);
`ifdef CACHE_STATS_EN
    check("rst_hit_count",  hit_count,  32'd0);
    check("rst_miss_count", miss_count, 32'd0);
`endif

    // Read miss with refill, then hit on the same word.
    base = log_addr.size();
    do_req(1'b0, 16'h0010, 16'h0, hit, rd, lat);
    check("t1_hit",    32'(hit), 32'd0);
    check("t1_rdata",  32'(rd),  32'hA5B5);
    check("t1_nwords", 32'(log_addr.size() - base), 32'd4);
    check("t1_nwr",    32'(count_writes(base)), 32'd0);
    for (int i = 0; i < 4; i++) check("t1_fill_addr", 32'(log_addr[base+i]), 32'h0010 + 32'(i));
    do_req(1'b0, 16'h0010, 16'h0, hit, rd, lat);
    check("t1_rehit",  32'(hit), 32'd1);
    check("t1_rerd",   32'(rd),  32'hA5B5);
    check("t1_hitlat", 32'(lat), 32'd2);

    // Write hit, then conflicting read evicts the dirty line.
    do_req(1'b1, 16'h0011, 16'h1234, hit, rd, lat);
    check("t2_whit",   32'(hit), 32'd1);
    check("t2_wrd",    32'(rd),  32'h1234);
    base = log_addr.size();
    do_req(1'b0, 16'h0211, 16'h0, hit, rd, lat);
    check("t2_hit",    32'(hit), 32'd0);
    check("t2_rdata",  32'(rd),  32'hA7B4);
    check("t2_nwords", 32'(log_addr.size() - base), 32'd8);
    for (int i = 0; i < 4; i++) begin
      check("t2_wb_we",     32'(log_we[base+i]),     32'd1);
      check("t2_wb_addr",   32'(log_addr[base+i]),   32'h0010 + 32'(i));
      check("t2_fill_we",   32'(log_we[base+4+i]),   32'd0);
      check("t2_fill_addr", 32'(log_addr[base+4+i]), 32'h0210 + 32'(i));
    end
    check("t2_wb_d0", 32'(log_data[base+0]), 32'hA5B5);
    check("t2_wb_d1", 32'(log_data[base+1]), 32'h1234);
    check("t2_wb_d2", 32'(log_data[base+2]), 32'hA5B7);
    check("t2_wb_d3", 32'(log_data[base+3]), 32'hA5B6);

    // Write miss allocates, re-read hits, eviction writes the new data back.
    base = log_addr.size();
    do_req(1'b1, 16'h0400, 16'hBEEF, hit, rd, lat);
    check("t3_hit",   32'(hit), 32'd0);
    check("t3_rdata", 32'(rd),  32'hBEEF);
    check("t3_nwr",   32'(count_writes(base)), 32'd0);
    check("t3_nfill", 32'(log_addr.size() - base), 32'd4);
    do_req(1'b0, 16'h0400, 16'h0, hit, rd, lat);
    check("t3_rehit", 32'(hit), 32'd1);
    check("t3_rerd",  32'(rd),  32'hBEEF);
    base = log_addr.size();
    do_req(1'b0, 16'h0000, 16'h0, hit, rd, lat);
    check("t3_ev_rdata", 32'(rd), 32'hA5A5);
    check("t3_ev_nwr",   32'(count_writes(base)), 32'd4);
    check("t3_ev_addr0", 32'(log_addr[base]), 32'h0400);
    check("t3_ev_data0", 32'(log_data[base]), 32'hBEEF);
    check("t3_ev_data1", 32'(log_data[base+1]), 32'hA1A4);

    // Reset during the third writeback word.
    do_req(1'b1, 16'h0212, 16'h5555, hit, rd, lat);
    check("t4_whit", 32'(hit), 32'd1);
    base = log_addr.size();
    @(negedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0012;
    @(negedge clk); #1;
    bus.req_valid = 1'b0;
    resp_base = n_resp;
    guard = 0;
    while (!(bus.mem_req && bus.mem_addr == 16'h0212 && (log_addr.size() - base) == 2) && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    check("t4_reach_wb2", 32'(guard < 200), 32'd1);
    check("t4_wb_we", 32'(bus.mem_we), 32'd1);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    check("t4_mem_req",   32'(bus.mem_req),   32'd0);
    check("t4_req_ready", 32'(bus.req_ready), 32'd1);
    check("t4_resp",      32'(bus.resp_valid), 32'd0);
`ifdef CACHE_STATS_EN
    check("t4_hit_count",  hit_count,  32'd0);
    check("t4_miss_count", miss_count, 32'd0);
`endif
    repeat (5) @(negedge clk);
    #1;
    check("t4_no_resp", 32'(n_resp - resp_base), 32'd0);
    base = log_addr.size();
    do_req(1'b0, 16'h0012, 16'h0, hit, rd, lat);
    check("t4_rehit",  32'(hit), 32'd0);
    check("t4_rerd",   32'(rd),  32'hA5B7);
    check("t4_nwr",    32'(count_writes(base)), 32'd0);
    check("t4_nfill",  32'(log_addr.size() - base), 32'd4);

    // req_valid held high across a miss and the following hit.
    base      = log_addr.size();
    acc_base  = n_accept;
    seen      = 0;
    guard     = 0;
    hits[0]   = 1'b1;
    hits[1]   = 1'b0;
    @(negedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0100;
    while (seen < 2 && guard < 500) begin
      @(negedge clk); #1;
      guard++;
      if (bus.resp_valid) begin
        hits[seen] = bus.resp_hit;
        seen++;
      end
    end
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("t5_nresp",    32'(seen), 32'd2);
    check("t5_naccept",  32'(n_accept - acc_base), 32'd2);
    check("t5_nwords",   32'(log_addr.size() - base), 32'd4);
    check("t5_hit0",     32'(hits[0]), 32'd0);
    check("t5_hit1",     32'(hits[1]), 32'd1);

    // All-ones address with zero-wait memory.
    mem_lat = 0;
    base = log_addr.size();
    do_req(1'b0, 16'hFFFF, 16'h0, hit, rd, lat);
    check("t6_hit",   32'(hit), 32'd0);
    check("t6_rdata", 32'(rd),  32'h5A5A);
    check("t6_addr0", 32'(log_addr[base]),   32'hFFFC);
    check("t6_addr3", 32'(log_addr[base+3]), 32'hFFFF);
    do_req(1'b0, 16'hFFFF, 16'h0, hit, rd, lat);
    check("t6_rehit", 32'(hit), 32'd1);
    check("t6_rerd",  32'(rd),  32'h5A5A);

`ifdef CACHE_STATS_EN
    repeat (3) @(negedge clk);
    check("stats_hits",   hit_count,  32'd2);
    check("stats_misses", miss_count, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/wb_cache_ctrl.md
Name: wb_cache_ctrl

Overview:
- Parametrised direct-mapped, write-back, write-allocate cache controller with a valid/ready request port and a word-serial backing-memory port.
- Successor to the fixed 16-bit, 2048-line cache. Adds configurable geometry, a request handshake, a multi-cycle memory handshake, dirty-line eviction before refill, and synchronous reset of line state.
- Sits between the CPU datapath and main memory.

Parameters:
- ADDR_W, 16, word-address width.
- DATA_W, 16, word width.
- INDEX_W, 7, line index bits; number of lines is 2^INDEX_W.
- OFFSET_W, 2, word-in-line bits; line length L is 2^OFFSET_W words.
- TAG_W is derived as ADDR_W-INDEX_W-OFFSET_W and must be at least 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address, split as {tag, index, offset}.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DATA_W  read data; on writes, the data just written.
- resp_hit  out  1  1 if the request hit.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = writeback word, 0 = refill word.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  writeback data.
- mem_ack  in  1  memory completed the current word.
- mem_rdata  in  DATA_W  refill data, valid with mem_ack.

Behaviour:
- Reset:
  - Every valid and dirty bit is cleared in the same cycle.
  - Outputs: req_ready=1, resp_valid=0, resp_hit=0, resp_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - State returns to IDLE.
  - Reset asserted mid-operation aborts the operation: no response is issued, mem_req is low in the cycle after reset, and a partially filled line stays invalid.
- FSM states: IDLE, LOOKUP, WB, FILL, DONE.
- Request acceptance:
  - req_ready=1 only in IDLE.
  - A request is accepted when req_valid and req_ready are both 1. Address, we and wdata are registered and the FSM goes to LOOKUP.
  - req_valid while not ready is ignored; there is no queueing.
- LOOKUP:
  - Hit means the line is valid and the stored tag equals the request tag.
  - On a hit: a read returns the stored word; a write updates the word and sets the line dirty. The FSM returns to IDLE, with resp_valid=1 and resp_hit=1 in the next cycle.
  - Hit latency is therefore accept edge N -> resp_valid high in cycle N+2. Back-to-back hits give one request every 2 cycles.
  - On a miss with a valid, dirty line: go to WB.
  - On a miss otherwise: go to FILL.
- WB:
  - Writes words 0..L-1 of the victim line to {old_tag, index, w}, with mem_we=1.
  - mem_req, mem_addr and mem_wdata are held stable until mem_ack is seen; the word counter then advances.
  - After word L-1 is acked: dirty is cleared and the FSM goes to FILL.
- FILL:
  - Reads words 0..L-1 from {new_tag, index, w}, with mem_we=0.
  - mem_rdata is captured on each mem_ack.
  - After word L-1: tag is stored, valid=1, and the FSM goes to DONE.
- DONE:
  - Performs the original request on the refilled line. A write sets dirty=1; a read leaves dirty=0.
  - resp_valid=1, resp_hit=0. The FSM returns to IDLE.
- Memory port:
  - mem_ack is ignored while mem_req=0.
  - mem_req drops for at least one cycle between WB and FILL.
  - There is no bound on ack latency; a 0-wait ack in the same cycle as the request is legal.
- Boundary conditions:
  - The word counter wraps from L-1 to 0 at the end of each phase.
  - Address all-ones maps to tag max, index max, offset max, with no overflow.
  - A miss to a line that is valid and clean never generates memory writes.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined, adds output ports hit_count (32 bits) and miss_count (32 bits).
  - Each counter increments on the resp_valid of the matching resp_hit value.
  - Counters saturate at 0xFFFFFFFF and are cleared by rst.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then read 0x0010 with memory returning addr^0xA5A5 after 3-cycle ack -> 4 refill reads at 0x0010..0x0013, resp_hit=0, resp_rdata=0x A5B5; an immediate re-read of 0x0010 gives resp_hit=1 and latency 2 cycles.
- Write 0x0011=0x1234 (hit), then read 0x0211 (same index, different tag, INDEX_W=7, OFFSET_W=2) -> 4 writebacks at 0x0010..0x0013 including 0x1234 at 0x0011, then 4 refills at 0x0210..0x0213, resp_hit=0.
- Write miss to 0x0400 with data 0xBEEF -> refill with no writeback; a subsequent read of 0x0400 hits and returns 0xBEEF; the line is dirty, so its next eviction writes 0xBEEF back.
- Assert rst during the third WB word -> no resp_valid, mem_req=0 on the next cycle, req_ready=1; a read of the same address then misses with no writeback.
- Hold req_valid high throughout a miss -> exactly one request is accepted per req_ready window; no extra memory traffic.
- With CACHE_STATS_EN defined, run 3 hits and 2 misses -> hit_count=3, miss_count=2; both read 0 after rst.
